adder: RTL and testbench
========================

ADDER -- requirements
Module: adder

Interface
REQ-001 Parameter WIDTH, default 1: operand/sum bit width; legal range 1..64.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 in_valid  input  1  operands a, b, cin qualified this cycle.
REQ-005 a  input  WIDTH  operand A, unsigned.
REQ-006 b  input  WIDTH  operand B, unsigned.
REQ-007 cin  input  1  carry-in.
REQ-008 out_valid  output  1  sum/cout/ovf hold a new result this cycle.
REQ-009 sum  output  WIDTH  registered a+b+cin, low WIDTH bits.
REQ-010 cout  output  1  registered carry-out, bit WIDTH of a+b+cin.
REQ-011 ovf  output  1  registered two's-complement overflow: operand MSBs equal, sum MSB differs.

Function
REQ-012 Arithmetic: {cout,sum} SHALL equal a+b+cin computed at WIDTH+1 bits, no truncation of carry.
REQ-013 For WIDTH=1 the block SHALL implement the full-adder truth table: sum=a^b^cin, cout=majority(a,b,cin).
REQ-014 Latency: result of operands sampled with in_valid=1 at edge N SHALL appear on sum/cout/ovf with out_valid=1 after edge N (1 cycle), with no ADDER_PIPE_EN.
REQ-015 Throughput: one new operation per cycle; back-to-back in_valid SHALL yield back-to-back out_valid.
REQ-016 in_valid=0 at an edge: sum/cout/ovf SHALL hold previous values; out_valid SHALL be 0 next cycle.
REQ-017 X/Z on a/b/cin while in_valid=0 SHALL NOT affect outputs.
REQ-018 Wrap-around: all-ones + all-ones + 1 SHALL give sum=all-ones, cout=1.
REQ-019 No backpressure; outputs are valid for exactly the cycle out_valid=1 and the consumer must sample them then.

Reset
REQ-020 rst=1 at an edge SHALL clear sum, cout, ovf, out_valid and any pipeline register to 0.
REQ-021 rst SHALL take priority over in_valid at the same edge; in-flight operation is discarded.
REQ-022 First result after rst deassertion SHALL come only from operands sampled with rst=0.

Configuration
REQ-023 Macro ADDER_PIPE_EN defined: an input register stage (a, b, cin, in_valid) SHALL be added; latency becomes 2 cycles; throughput remains one per cycle; reset clears both stages.
REQ-024 ADDER_PIPE_EN undefined: single output register stage, latency 1 cycle, per REQ-014.
REQ-025 Arithmetic results SHALL be identical in both configurations; only latency differs.

Verification
REQ-026 WIDTH=1, drive all 8 (a,b,cin) combos with in_valid=1 -> e.g. 1 1 1 gives sum=1 cout=1; 1 0 0 gives sum=1 cout=0; 0 0 0 gives sum=0 cout=0.
REQ-027 WIDTH=8, a=8'hFF b=8'hFF cin=1 -> sum=8'hFF cout=1 ovf=0; a=8'h7F b=8'h01 cin=0 -> sum=8'h80 cout=0 ovf=1.
REQ-028 Assert rst with in_valid=1 a=3 b=4 -> next cycle sum=0 cout=0 ovf=0 out_valid=0.
REQ-029 in_valid pattern 1,0,1 -> out_valid pattern 1,0,1 delayed by latency; sum held during gap.
REQ-030 Rebuild with ADDER_PIPE_EN, repeat REQ-027 -> identical results, out_valid two cycles after in_valid.

Source files
------------

// File: rtl/adder_if.sv
// rtl/adder_if.sv - operand/result bundle between an adder producer and the adder
interface adder_if #(
    parameter int WIDTH = 1
);
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin,
        input  out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin,
        output out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/adder.sv
// rtl/adder.sv - registered WIDTH-bit adder with carry and overflow; ADDER_PIPE_EN adds an input stage
module adder #(
    parameter int WIDTH = 1
) (
    input  logic    clk,
    input  logic    rst,
    adder_if.slave  bus
);

    logic             op_valid;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             op_cin;

`ifdef ADDER_PIPE_EN
    logic             in_valid_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             cin_q;

    // Operands are only captured when qualified, so idle-cycle garbage never enters the pipe.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_valid_q <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            cin_q      <= 1'b0;
        end else begin
            in_valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                a_q   <= bus.a;
                b_q   <= bus.b;
                cin_q <= bus.cin;
            end
        end
    end

    assign op_valid = in_valid_q;
    assign op_a     = a_q;
    assign op_b     = b_q;
    assign op_cin   = cin_q;
`else
    assign op_valid = bus.in_valid;
    assign op_a     = bus.a;
    assign op_b     = bus.b;
    assign op_cin   = bus.cin;
`endif

    logic [WIDTH:0]   full_sum;
    logic [WIDTH-1:0] sum_d, sum_q;
    logic             cout_d, cout_q;
    logic             ovf_d, ovf_q;
    logic             out_valid_q;

    assign full_sum = {1'b0, op_a} + {1'b0, op_b} + {{WIDTH{1'b0}}, op_cin};

    always_comb begin
        sum_d  = sum_q;
        cout_d = cout_q;
        ovf_d  = ovf_q;
        if (op_valid) begin
            sum_d  = full_sum[WIDTH-1:0];
            cout_d = full_sum[WIDTH];
            ovf_d  = (op_a[WIDTH-1] == op_b[WIDTH-1]) &&
                     (full_sum[WIDTH-1] != op_a[WIDTH-1]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            out_valid_q <= op_valid;
        end
    end

    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
    assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_adder.sv
// tb/tb_adder.sv - checks a 1-bit and an 8-bit adder against an arithmetic reference
module tb_adder;

`ifdef ADDER_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    adder_if #(.WIDTH(1)) if1 ();
    adder_if #(.WIDTH(8)) if8 ();

    adder #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
    adder #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(if8.slave));

    int n_vec = 0;
    int n_bad = 0;

    // Reference state: index 0 is the 1-bit adder, index 1 the 8-bit adder
    bit     live = 1'b0;
    bit     st_v [2];
    longint st_a [2];
    longint st_b [2];
    bit     st_c [2];
    bit     ex_v [2];
    longint ex_s [2];
    bit     ex_co[2];
    bit     ex_ov[2];

    function automatic void ref_add(input int w, input longint a, input longint b, input bit c,
                                    output longint s, output bit co, output bit ov);
        longint full, sa, sb, ss, half;
        half = longint'(1) << (w - 1);
        full = a + b + longint'(c);
        s    = full & ((longint'(1) << w) - 1);
        co   = ((full >> w) & 1) != 0;
        sa   = (a >= half) ? a - 2 * half : a;
        sb   = (b >= half) ? b - 2 * half : b;
        ss   = sa + sb + longint'(c);
        ov   = (ss > half - 1) || (ss < -half);
    endfunction

    always @(posedge clk) begin
        bit     v[2];
        longint a[2];
        longint b[2];
        bit     c[2];
        bit     dv;
        longint da, db;
        bit     dc;
        v[0] = if1.in_valid; a[0] = longint'(if1.a); b[0] = longint'(if1.b); c[0] = if1.cin;
        v[1] = if8.in_valid; a[1] = longint'(if8.a); b[1] = longint'(if8.b); c[1] = if8.cin;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                st_v[k] = 1'b0; ex_v[k] = 1'b0; ex_s[k] = 0; ex_co[k] = 1'b0; ex_ov[k] = 1'b0;
            end else begin
                if (LAT == 2) begin
                    dv = st_v[k]; da = st_a[k]; db = st_b[k]; dc = st_c[k];
                end else begin
                    dv = v[k]; da = a[k]; db = b[k]; dc = c[k];
                end
                ex_v[k] = dv;
                if (dv) ref_add((k == 0) ? 1 : 8, da, db, dc, ex_s[k], ex_co[k], ex_ov[k]);
                st_v[k] = v[k]; st_a[k] = a[k]; st_b[k] = b[k]; st_c[k] = c[k];
            end
        end
        if (rst) live = 1'b1;
    end

    task automatic check_out(input string name, input int k, input logic v, input longint s,
                             input logic co, input logic ov);
        n_vec++;
        if (v !== ex_v[k] || s != ex_s[k] || co !== ex_co[k] || ov !== ex_ov[k]) begin
            n_bad++;
            $display("FAIL %s @%0t: got v=%0b sum=%0h cout=%0b ovf=%0b, want v=%0b sum=%0h cout=%0b ovf=%0b",
                     name, $time, v, s, co, ov, ex_v[k], ex_s[k], ex_co[k], ex_ov[k]);
        end
    endtask

    task automatic compare();
        if (live) begin
            check_out("dut1", 0, if1.out_valid, longint'(if1.sum), if1.cout, if1.ovf);
            check_out("dut8", 1, if8.out_valid, longint'(if8.sum), if8.cout, if8.ovf);
        end
    endtask

    task automatic lit(input string name, input longint act, input longint exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        compare();
    endtask

    task automatic set1(input logic a, input logic b, input logic c);
        if1.in_valid = 1'b1; if1.a = a; if1.b = b; if1.cin = c;
    endtask

    task automatic idle1();
        if1.in_valid = 1'b0; if1.a = 1'($urandom); if1.b = 1'($urandom); if1.cin = 1'($urandom);
    endtask

    task automatic set8(input logic [7:0] a, input logic [7:0] b, input logic c);
        if8.in_valid = 1'b1; if8.a = a; if8.b = b; if8.cin = c;
    endtask

    task automatic idle8();
        if8.in_valid = 1'b0; if8.a = 8'($urandom); if8.b = 8'($urandom); if8.cin = 1'($urandom);
    endtask

    task automatic op1(input logic a, input logic b, input logic c,
                       input logic es, input logic ec, input string name);
        set1(a, b, c);
        tick();
        idle1();
        if (LAT == 2) tick();
        lit({name, "_valid"}, longint'(if1.out_valid), 1);
        lit({name, "_sum"},   longint'(if1.sum),       longint'(es));
        lit({name, "_cout"},  longint'(if1.cout),      longint'(ec));
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c,
                       input logic [7:0] es, input logic ec, input logic eo, input string name);
        set8(a, b, c);
        tick();
        idle8();
        if (LAT == 2) tick();
        lit({name, "_valid"}, longint'(if8.out_valid), 1);
        lit({name, "_sum"},   longint'(if8.sum),       longint'(es));
        lit({name, "_cout"},  longint'(if8.cout),      longint'(ec));
        lit({name, "_ovf"},   longint'(if8.ovf),       longint'(eo));
    endtask

    logic         obs_v[4];
    logic [7:0]   obs_s[4];
    longint       ps;
    bit           pc, po;

    initial begin
        rst = 1'b1;
        idle1();
        idle8();
        tick();
        tick();
        lit("rst_valid8", longint'(if8.out_valid), 0);
        lit("rst_sum8",   longint'(if8.sum),       0);
        lit("rst_valid1", longint'(if1.out_valid), 0);
        rst = 1'b0;

        op1(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, "fa_111");
        op1(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "fa_100");
        op1(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "fa_000");
        for (int i = 0; i < 8; i++) begin
            set1(i[2], i[1], i[0]);
            tick();
        end
        idle1();
        tick();
        tick();

        op8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, "wrap");
        op8(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, "ovf");

        set8(8'd3, 8'd4, 1'b0);
        set1(1'b1, 1'b1, 1'b1);
        rst = 1'b1;
        tick();
        lit("rstpri_valid", longint'(if8.out_valid), 0);
        lit("rstpri_sum",   longint'(if8.sum),       0);
        lit("rstpri_cout",  longint'(if8.cout),      0);
        lit("rstpri_ovf",   longint'(if8.ovf),       0);
        rst = 1'b0;
        idle1();
        idle8();
        tick();
        tick();

        set8(8'd10, 8'd20, 1'b0); tick(); obs_v[0] = if8.out_valid; obs_s[0] = if8.sum;
        idle8();                  tick(); obs_v[1] = if8.out_valid; obs_s[1] = if8.sum;
        set8(8'd5, 8'd6, 1'b0);   tick(); obs_v[2] = if8.out_valid; obs_s[2] = if8.sum;
        idle8();                  tick(); obs_v[3] = if8.out_valid; obs_s[3] = if8.sum;
        lit("gap_v0", longint'(obs_v[LAT-1]), 1);
        lit("gap_s0", longint'(obs_s[LAT-1]), 30);
        lit("gap_v1", longint'(obs_v[LAT]),   0);
        lit("gap_s1", longint'(obs_s[LAT]),   30);
        lit("gap_v2", longint'(obs_v[LAT+1]), 1);
        lit("gap_s2", longint'(obs_s[LAT+1]), 11);

        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(3) != 0) set1(1'($urandom), 1'($urandom), 1'($urandom)); else idle1();
            if ($urandom_range(3) != 0) set8(8'($urandom), 8'($urandom), 1'($urandom)); else idle8();
            rst = (i == 30);
            tick();
        end
        rst = 1'b0;
        idle1();
        idle8();
        tick();
        tick();
        tick();

        ref_add(8, 255, 255, 1'b1, ps, pc, po);
        lit("model_wrap_sum", ps, 255);
        lit("model_wrap_cout", longint'(pc), 1);
        ref_add(8, 127, 1, 1'b0, ps, pc, po);
        lit("model_ovf", longint'(po), 1);
        ref_add(1, 0, 0, 1'b1, ps, pc, po);
        lit("model_fa001_sum", ps, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
